// File: rtl/num_ascii_formatter.sv
// Reads signed words from a number RAM and streams them as space-separated
// decimal ASCII toward a byte-wide valid/ready transmitter.
module num_ascii_formatter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  start,
  input  logic [10:0]           num_count,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  output logic                  tx_last,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CW   = ADDR_WIDTH + 1;
  localparam int unsigned NDIG = 10;
  localparam logic [CW-1:0] MAX_CNT   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [7:0]    ASC_MINUS = 8'h2D;
  localparam logic [7:0]    ASC_SPACE = 8'h20;

  typedef enum logic [2:0] {
    IDLE, READ, WAIT, CONV, EMIT_SIGN, EMIT_DIG, EMIT_SEP, FINISH
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  neg_q, neg_d;
  logic [31:0]           mag_q, mag_d;
  logic [3:0]            dig_q [NDIG];
  logic [3:0]            dig_d [NDIG];
  logic [3:0]            ndig_q, ndig_d;
  logic [3:0]            pos_q, pos_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  tx_last_q, tx_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [31:0]           quot;
  logic [3:0]            rem;
  logic [DATA_WIDTH-1:0] abs_val;
  logic                  is_last;
  logic                  xfer;

  // One decimal digit per cycle from the running magnitude
  always_comb begin
    quot    = mag_q / 32'd10;
    rem     = 4'(mag_q % 32'd10);
    abs_val = rd_data[DATA_WIDTH-1] ? (~rd_data + DATA_WIDTH'(1)) : rd_data;
    is_last = (idx_q + CW'(1)) == cnt_q;
    xfer    = tx_valid_q && tx_ready;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    neg_d      = neg_q;
    mag_d      = mag_q;
    dig_d      = dig_q;
    ndig_d     = ndig_q;
    pos_d      = pos_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = (32'(num_count) > 32'(MAX_CNT)) ? MAX_CNT : CW'(num_count);
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        if (idx_q >= cnt_q) begin
          done_d  = 1'b1;
          state_d = FINISH;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        neg_d   = rd_data[DATA_WIDTH-1];
        mag_d   = 32'(abs_val);
        ndig_d  = '0;
        state_d = CONV;
      end
      // Final step presents the top digit straight from rem so no bubble appears
      CONV: begin
        dig_d[ndig_q] = rem;
        ndig_d        = ndig_q + 4'd1;
        mag_d         = quot;
        if (quot == 32'd0) begin
          pos_d      = ndig_q;
          tx_valid_d = 1'b1;
          if (neg_q) begin
            tx_data_d = ASC_MINUS;
            tx_last_d = 1'b0;
            state_d   = EMIT_SIGN;
          end else begin
            tx_data_d = {4'h3, rem};
            tx_last_d = is_last && (ndig_q == 4'd0);
            state_d   = EMIT_DIG;
          end
        end
      end
      EMIT_SIGN: begin
        if (xfer) begin
          tx_data_d = {4'h3, dig_q[pos_q]};
          tx_last_d = is_last && (pos_q == 4'd0);
          state_d   = EMIT_DIG;
        end
      end
      EMIT_DIG: begin
        if (xfer) begin
          if (pos_q == 4'd0) begin
            tx_last_d = 1'b0;
            if (is_last) begin
              tx_valid_d = 1'b0;
              done_d     = 1'b1;
              state_d    = FINISH;
            end else begin
              tx_data_d = ASC_SPACE;
              state_d   = EMIT_SEP;
            end
          end else begin
            pos_d     = pos_q - 4'd1;
            tx_data_d = {4'h3, dig_q[pos_q - 4'd1]};
            tx_last_d = is_last && (pos_q == 4'd1);
          end
        end
      end
      EMIT_SEP: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          idx_d      = idx_q + CW'(1);
          state_d    = READ;
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      state_d    = IDLE;
      idx_d      = '0;
      tx_valid_d = 1'b0;
      tx_last_d  = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
    end

    rd_addr_d = ADDR_WIDTH'(idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      rd_addr_q  <= '0;
      neg_q      <= 1'b0;
      mag_q      <= '0;
      for (int i = 0; i < NDIG; i++) dig_q[i] <= '0;
      ndig_q     <= '0;
      pos_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rd_addr_q  <= rd_addr_d;
      neg_q      <= neg_d;
      mag_q      <= mag_d;
      dig_q      <= dig_d;
      ndig_q     <= ndig_d;
      pos_q      <= pos_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rd_addr  = rd_addr_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
